rx_uart: RTL and testbench
==========================

// Module: rx_uart
// PURPOSE
//  UART serial receiver; the receive-side counterpart of the UART transmitter.
//  Samples i_rx with an oversampling tick (N_TICK ticks per bit, from the shared baud generator).
//  Recovers 1 start bit, DATA_BITS data bits (LSB first) and STOP_BITS stop bits.
//  Presents each received word on o_data with a one-cycle o_rx_done strobe, or flags a framing error.
// PARAMETERS
//  DATA_BITS         8                   data bits per frame
//  STOP_BITS         1                   stop bits per frame (1 or 2)
//  N_TICK            16                  i_tick pulses per bit period (even, >= 4)
//  LEN_TICK_COUNTER  $clog2(N_TICK)      tick counter width
//  LEN_DATA_COUNTER  $clog2(DATA_BITS)   data-bit counter width
// PORTS
//  i_clock        in   1          single system clock, rising edge
//  i_reset        in   1          asynchronous, active-low reset
//  i_tick         in   1          oversampling strobe, one i_clock cycle wide
//  i_rx           in   1          serial line, idle high, asynchronous to i_clock
//  o_data         out  DATA_BITS  last correctly framed word, held until next good frame
//  o_rx_done      out  1          one-cycle pulse, o_data valid/updated this cycle
//  o_frame_error  out  1          one-cycle pulse, a stop bit was sampled low
// BEHAVIOUR
//  - Reset (i_reset=0, async): state=IDLE; tick/data counters=0; shift reg=0; o_data=0;
//    o_rx_done=0; o_frame_error=0; both synchronizer flops=1.
//  - i_rx passes a 2-flop synchronizer (rx_s); all decisions use rx_s. No tick gating on the synchronizer.
//  - All outputs are registered. Counters advance only in cycles with i_tick=1.
//  - FSM, one-hot, states IDLE, START, DATA, STOP:
//    IDLE:  if rx_s==0 -> START, tick_cnt=0 (no tick required for detection).
//    START: on tick, if tick_cnt==N_TICK/2-1 (mid start bit):
//           rx_s==0 -> DATA, tick_cnt=0, data_cnt=0;
//           rx_s==1 -> IDLE (glitch rejected, no output pulse); else tick_cnt++.
//    DATA:  on tick, if tick_cnt==N_TICK-1 (mid data bit): shift={rx_s,shift[DATA_BITS-1:1]},
//           tick_cnt=0; if data_cnt==DATA_BITS-1 -> STOP with stop_cnt=0, else data_cnt++.
//           Otherwise tick_cnt++.
//    STOP:  on tick, if tick_cnt==N_TICK-1 (mid stop bit): record rx_s, tick_cnt=0.
//           After the last stop bit: -> IDLE.
//             - If every stop sample was 1: o_data<=shift and o_rx_done=1 (next clock edge).
//             - Otherwise: o_frame_error=1 and o_data is unchanged.
//           Otherwise tick_cnt++.
//  - Latency: o_rx_done rises on the clock edge after the tick that samples the last stop bit.
//    That is (1.5+DATA_BITS+STOP_BITS-1) bit times after the start edge, plus 2 sync cycles.
//  - Back-to-back frames: IDLE is re-entered at mid stop bit, so a start edge arriving
//    half a bit later is caught. No idle gap is required.
//  - Line held low (break): frame error reported, then re-enters START while the line stays low.
//    This repeats, one frame error per frame time.
//  - o_rx_done and o_frame_error are never both 1; each lasts exactly one i_clock cycle.
//  - i_tick inactive: FSM holds state and counters (IDLE start detection still works).
//  - Reset mid-frame: immediate return to IDLE; the partial word is discarded; no pulse.
//  - Illegal state encoding: -> IDLE with counters and shift register cleared.
// TESTING
//  1 Frame 0xA5 (8N1, N_TICK=16, tick every 4 clk) -> one o_rx_done pulse, o_data=0xA5, o_frame_error=0.
//  2 Frames 0x00 then 0xFF sent back-to-back, 1 stop bit, no gap -> two o_rx_done pulses, o_data=0x00 then 0xFF.
//  3 Low glitch of 3 ticks on idle line -> FSM returns to IDLE, no pulses, o_data unchanged.
//  4 Frame 0x3C with stop bit driven 0 -> o_frame_error pulse, no o_rx_done, o_data keeps previous value.
//  5 i_reset low during data bit 4 of 0x55, then a clean frame 0x81 -> no pulse for 0x55, o_data=0x81 after the second frame.
//  6 STOP_BITS=2, second stop bit 0 -> o_frame_error; both stop bits 1 -> o_rx_done with the correct word.

Source files
------------

// File: rtl/rx_uart.sv
// rtl/rx_uart.sv - UART receiver: 2-flop synchronizer, oversampled start/data/stop recovery
module rx_uart #(
    parameter int DATA_BITS        = 8,
    parameter int STOP_BITS        = 1,
    parameter int N_TICK           = 16,
    parameter int LEN_TICK_COUNTER = $clog2(N_TICK),
    parameter int LEN_DATA_COUNTER = $clog2(DATA_BITS)
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_tick,
    input  logic                 i_rx,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_rx_done,
    output logic                 o_frame_error
);

    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        DATA  = 4'b0100,
        STOP  = 4'b1000
    } state_t;

    localparam logic [LEN_TICK_COUNTER-1:0] TICK_HALF = LEN_TICK_COUNTER'(N_TICK / 2 - 1);
    localparam logic [LEN_TICK_COUNTER-1:0] TICK_LAST = LEN_TICK_COUNTER'(N_TICK - 1);
    localparam logic [LEN_DATA_COUNTER-1:0] DATA_LAST = LEN_DATA_COUNTER'(DATA_BITS - 1);
    localparam logic                        STOP_LAST = 1'(STOP_BITS - 1);

    state_t                      state;
    logic                        rx_meta;
    logic                        rx_s;
    logic [LEN_TICK_COUNTER-1:0] tick_cnt;
    logic [LEN_DATA_COUNTER-1:0] data_cnt;
    logic                        stop_cnt;
    logic                        stop_ok;
    logic [DATA_BITS-1:0]        shift;

    // Synchronizer resets to the idle (high) line level so reset never looks like a start edge
    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            data_cnt      <= '0;
            stop_cnt      <= 1'b0;
            stop_ok       <= 1'b0;
            shift         <= '0;
            o_data        <= '0;
            o_rx_done     <= 1'b0;
            o_frame_error <= 1'b0;
        end else begin
            o_rx_done     <= 1'b0;
            o_frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state    <= START;
                        tick_cnt <= '0;
                    end
                end
                START: begin
                    if (i_tick) begin
                        if (tick_cnt == TICK_HALF) begin
                            if (!rx_s) begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                data_cnt <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (i_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            shift    <= {rx_s, shift[DATA_BITS-1:1]};
                            tick_cnt <= '0;
                            if (data_cnt == DATA_LAST) begin
                                state    <= STOP;
                                stop_cnt <= 1'b0;
                                stop_ok  <= 1'b1;
                            end else begin
                                data_cnt <= data_cnt + 1'b1;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                STOP: begin
                    if (i_tick) begin
                        if (tick_cnt == TICK_LAST) begin
                            tick_cnt <= '0;
                            // Leaving at mid stop bit lets a back-to-back start edge be caught
                            if (stop_cnt == STOP_LAST) begin
                                state <= IDLE;
                                if (stop_ok && rx_s) begin
                                    o_data    <= shift;
                                    o_rx_done <= 1'b1;
                                end else begin
                                    o_frame_error <= 1'b1;
                                end
                            end else begin
                                stop_cnt <= stop_cnt + 1'b1;
                                stop_ok  <= stop_ok & rx_s;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    tick_cnt <= '0;
                    data_cnt <= '0;
                    stop_cnt <= 1'b0;
                    stop_ok  <= 1'b0;
                    shift    <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rx_uart.sv
// tb/tb_rx_uart.sv - scoreboard bench for rx_uart with 1-stop and 2-stop instances
module tb_rx_uart;

    localparam int BIT_CLK = 64;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx0 = 1'b1;
    logic       rx1 = 1'b1;
    logic [1:0] tdiv = 2'd0;
    logic       tick;
    logic [7:0] data0, data1;
    logic       done0, done1, ferr0, ferr1;

    exp_t       q0[$];
    exp_t       q1[$];
    exp_t       e0, e1;
    logic [7:0] last_good[2];
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tdiv <= tdiv + 2'd1;
    assign tick = (tdiv == 2'd3);

    rx_uart #(.DATA_BITS(8), .STOP_BITS(1), .N_TICK(16)) dut0 (
        .i_clock(clk), .i_reset(rst_n), .i_tick(tick), .i_rx(rx0),
        .o_data(data0), .o_rx_done(done0), .o_frame_error(ferr0)
    );

    rx_uart #(.DATA_BITS(8), .STOP_BITS(2), .N_TICK(16)) dut1 (
        .i_clock(clk), .i_reset(rst_n), .i_tick(tick), .i_rx(rx1),
        .o_data(data1), .o_rx_done(done1), .o_frame_error(ferr1)
    );

    // A frame is good only if every stop bit is 1; a bad frame leaves the last good word on o_data
    function automatic exp_t model(input int ch, input logic [7:0] d, input logic [1:0] stops, input int nstop);
        exp_t r;
        if (stops[0] && (nstop == 1 || stops[1])) begin
            last_good[ch] = d;
            r.err  = 1'b0;
            r.data = d;
        end else begin
            r.err  = 1'b1;
            r.data = last_good[ch];
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (rst_n && (done0 || ferr0)) begin
            checks++;
            if (done0 && ferr0) begin
                failures++;
                $display("FAIL both_pulses_ch0 done=%0b ferr=%0b required=exclusive", done0, ferr0);
            end else if (q0.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse_ch0 done=%0b ferr=%0b data=%02h required=none", done0, ferr0, data0);
            end else begin
                e0 = q0.pop_front();
                if (ferr0 !== e0.err || data0 !== e0.data) begin
                    failures++;
                    $display("FAIL event_ch0 ferr=%0b data=%02h required ferr=%0b data=%02h", ferr0, data0, e0.err, e0.data);
                end
            end
        end
        if (rst_n && (done1 || ferr1)) begin
            checks++;
            if (done1 && ferr1) begin
                failures++;
                $display("FAIL both_pulses_ch1 done=%0b ferr=%0b required=exclusive", done1, ferr1);
            end else if (q1.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse_ch1 done=%0b ferr=%0b data=%02h required=none", done1, ferr1, data1);
            end else begin
                e1 = q1.pop_front();
                if (ferr1 !== e1.err || data1 !== e1.data) begin
                    failures++;
                    $display("FAIL event_ch1 ferr=%0b data=%02h required ferr=%0b data=%02h", ferr1, data1, e1.err, e1.data);
                end
            end
        end
    end

    task automatic drive(input int ch, input logic v, input int n);
        if (ch == 0) rx0 = v;
        else         rx1 = v;
        repeat (n) @(posedge clk);
    endtask

    // rst_bit >= 0 aborts the frame with a reset during that data bit; no response is expected
    task automatic send(input int ch, input logic [7:0] d, input logic [1:0] stops, input int nstop, input int rst_bit);
        if (rst_bit < 0) begin
            if (ch == 0) q0.push_back(model(ch, d, stops, nstop));
            else         q1.push_back(model(ch, d, stops, nstop));
        end
        drive(ch, 1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) begin
            if (i == rst_bit) begin
                drive(ch, d[i], BIT_CLK / 2);
                rst_n = 1'b0;
                last_good[0] = 8'h00;
                last_good[1] = 8'h00;
                drive(ch, d[i], BIT_CLK / 2);
            end else begin
                drive(ch, d[i], BIT_CLK);
            end
        end
        for (int s = 0; s < nstop; s++) begin
            if (stops[s]) begin
                drive(ch, 1'b1, BIT_CLK);
            end else begin
                drive(ch, 1'b0, 48);
                drive(ch, 1'b1, BIT_CLK - 48);
            end
        end
        if (rst_bit >= 0) rst_n = 1'b1;
    endtask

    task automatic drain(input int ch);
        int n = 0;
        while (n < 3000 && ((ch == 0) ? q0.size() : q1.size()) != 0) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (((ch == 0) ? q0.size() : q1.size()) != 0) begin
            failures++;
            $display("FAIL drain_ch%0d pending=%0d required=0", ch, (ch == 0) ? q0.size() : q1.size());
        end
    endtask

    task automatic check_data(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%02h required=%02h", name, act, req);
        end
    endtask

    initial begin
        logic [7:0] d;
        logic [1:0] st;
        last_good[0] = 8'h00;
        last_good[1] = 8'h00;

        repeat (5) @(posedge clk);
        #1;
        check_data("reset_data0", data0, 8'h00);
        check_data("reset_data1", data1, 8'h00);
        check_data("reset_pulses", {4'd0, done0, ferr0, done1, ferr1}, 8'h00);
        rst_n = 1'b1;
        repeat (BIT_CLK) @(posedge clk);

        send(0, 8'hA5, 2'b01, 1, -1);
        drain(0);
        check_data("frame_a5", data0, 8'hA5);

        send(0, 8'h00, 2'b01, 1, -1);
        send(0, 8'hFF, 2'b01, 1, -1);
        drain(0);
        check_data("back_to_back", data0, 8'hFF);

        drive(0, 1'b0, 12);
        drive(0, 1'b1, 4 * BIT_CLK);
        check_data("glitch_keeps_data", data0, last_good[0]);

        send(0, 8'h3C, 2'b00, 1, -1);
        drive(0, 1'b1, 2 * BIT_CLK);
        drain(0);
        check_data("frame_error_keeps", data0, 8'hFF);

        send(0, 8'h55, 2'b01, 1, 4);
        #1;
        check_data("after_abort_reset", data0, 8'h00);
        drive(0, 1'b1, BIT_CLK);
        send(0, 8'h81, 2'b01, 1, -1);
        drain(0);
        check_data("clean_after_reset", data0, 8'h81);

        send(1, 8'hC3, 2'b01, 2, -1);
        drive(1, 1'b1, 2 * BIT_CLK);
        drain(1);
        check_data("two_stop_err_keeps", data1, 8'h00);
        send(1, 8'h5A, 2'b11, 2, -1);
        drain(1);
        check_data("two_stop_good", data1, 8'h5A);

        for (int k = 0; k < 16; k++) begin
            d  = 8'($urandom);
            st = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01;
            send(0, d, st, 1, -1);
            drive(0, 1'b1, st[0] ? $urandom_range(0, 50) : BIT_CLK + $urandom_range(0, 50));
        end
        drain(0);
        check_data("random_ch0_final", data0, last_good[0]);

        for (int k = 0; k < 8; k++) begin
            d  = 8'($urandom);
            st = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
            send(1, d, st, 2, -1);
            drive(1, 1'b1, (st == 2'b11) ? $urandom_range(0, 50) : BIT_CLK + $urandom_range(0, 50));
        end
        drain(1);
        check_data("random_ch1_final", data1, last_good[1]);

        repeat (BIT_CLK) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
